// File: rtl/box_layer_mapper.sv
// Box-layer sprite renderer: double-buffered object table, per-object flash
// counters, and a 2-stage hit-test/colour pipeline running at one pixel per clock.
module box_layer_mapper #(
    parameter  int N_OBJ        = 4,
    parameter  int W            = 10,
    parameter  int FLASH_FRAMES = 8,
    localparam int IW           = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_start,
    input  logic          de,
    input  logic [W-1:0]  DrawX,
    input  logic [W-1:0]  DrawY,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_x,
    input  logic [W-1:0]  wr_y,
    input  logic [W-1:0]  wr_sx,
    input  logic [W-1:0]  wr_sy,
    input  logic [23:0]   wr_rgb,
    input  logic          wr_vis,
    input  logic          flash_trig,
    input  logic [IW-1:0] flash_idx,
    output logic [7:0]    Red,
    output logic [7:0]    Green,
    output logic [7:0]    Blue,
    output logic          pix_valid
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] sx;
        logic [W-1:0] sy;
        logic [23:0]  rgb;
        logic         vis;
    } obj_t;

    obj_t        shadow_q [N_OBJ];
    obj_t        active_q [N_OBJ];
    logic [7:0]  flash_q  [N_OBJ];
    obj_t        wr_obj;

    logic [N_OBJ-1:0] hit_d, hit_q;
    logic [W-4:0]     xs_q;
    logic             de_q;
    logic [23:0]      rgb_d, rgb_q;
    logic             valid_q;
    logic [7:0]       bg_d;

    assign wr_obj = '{wr_x, wr_y, wr_sx, wr_sy, wr_rgb, wr_vis};

    function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[W] ? (~d + 1'b1) : d;
    endfunction

    // The active table is read only by the renderer; frame_start samples the
    // pre-write shadow, so a coincident write lands one frame later.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: the tables are reset explicitly so no stale box can render
            // after reset; this forces flops rather than RAM, which is fine at this size.
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                flash_q[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (frame_start)
                    active_q[i] <= shadow_q[i];
                if (wr_en && int'(wr_idx) == i)
                    shadow_q[i] <= wr_obj;
                if (flash_trig && int'(flash_idx) == i)
                    flash_q[i] <= 8'(FLASH_FRAMES);
                else if (frame_start && flash_q[i] != 8'd0)
                    flash_q[i] <= flash_q[i] - 8'd1;
            end
        end
    end

    // |d| <= s>>1 is evaluated as 2|d| <= s, which is identical for integers.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        hit_d = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            hit_d[i] = active_q[i].vis
                && ({abs_diff(DrawX, active_q[i].x), 1'b0} <= {2'b00, active_q[i].sx})
                && ({abs_diff(DrawY, active_q[i].y), 1'b0} <= {2'b00, active_q[i].sy});
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_q <= '0;
            xs_q  <= '0;
            de_q  <= 1'b0;
        end else begin
            hit_q <= hit_d;
            xs_q  <= DrawX[W-1:3];
            de_q  <= de;
        end
    end

    // Lowest index wins: scan downwards so the last assignment is the lowest hit.
    always_comb begin
        bg_d  = 8'h7F - 8'(xs_q);
        rgb_d = {16'h0000, bg_d};
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_q[i])
                rgb_d = (flash_q[i] != 8'd0) ? 24'hFFFFFF : active_q[i].rgb;
        end
        if (!de_q)
            rgb_d = 24'h000000;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb_q   <= 24'h000000;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= de_q;
        end
    end

    assign Red       = rgb_q[23:16];
    assign Green     = rgb_q[15:8];
    assign Blue      = rgb_q[7:0];
    assign pix_valid = valid_q;

endmodule

// File: tb/tb_box_layer_mapper.sv
// Self-checking bench for box_layer_mapper: directed scenarios plus random
// traffic, compared against an integer-arithmetic model of the pixel rules.
module tb_box_layer_mapper;

    localparam int N_OBJ        = 3;
    localparam int W            = 10;
    localparam int FLASH_FRAMES = 3;
    localparam int IW           = 2;

    logic          Clk, Reset, frame_start, de;
    logic [W-1:0]  DrawX, DrawY;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_x, wr_y, wr_sx, wr_sy;
    logic [23:0]   wr_rgb;
    logic          wr_vis, flash_trig;
    logic [IW-1:0] flash_idx;
    logic [7:0]    Red, Green, Blue;
    logic          pix_valid;

    box_layer_mapper #(.N_OBJ(N_OBJ), .W(W), .FLASH_FRAMES(FLASH_FRAMES)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .de(de),
        .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_sx(wr_sx), .wr_sy(wr_sy),
        .wr_rgb(wr_rgb), .wr_vis(wr_vis), .flash_trig(flash_trig),
        .flash_idx(flash_idx), .Red(Red), .Green(Green), .Blue(Blue),
        .pix_valid(pix_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct { int x; int y; int sx; int sy; int rgb; bit vis; } mobj_t;
    typedef struct { int rgb; bit v; } pix_t;

    mobj_t m_sh [N_OBJ];
    mobj_t m_act[N_OBJ];
    int    m_fl [N_OBJ];
    pix_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string phase  = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_OBJ; i++) begin
            m_sh[i]  = '{0, 0, 0, 0, 0, 1'b0};
            m_act[i] = '{0, 0, 0, 0, 0, 1'b0};
            m_fl[i]  = 0;
        end
    endfunction

    function automatic pix_t model_pix(input int px, input int py, input bit d);
        pix_t p;
        int   dx, dy;
        p.v   = d;
        p.rgb = 0;
        if (!d) return p;
        p.rgb = (127 - (px / 8)) & 255;
        for (int i = 0; i < N_OBJ; i++) begin
            dx = px - m_act[i].x; if (dx < 0) dx = -dx;
            dy = py - m_act[i].y; if (dy < 0) dy = -dy;
            if (m_act[i].vis && dx <= m_act[i].sx / 2 && dy <= m_act[i].sy / 2) begin
                p.rgb = (m_fl[i] > 0) ? 32'h00FFFFFF : m_act[i].rgb;
                return p;
            end
        end
        return p;
    endfunction

    function automatic void model_apply();
        if (frame_start)
            for (int i = 0; i < N_OBJ; i++) m_act[i] = m_sh[i];
        for (int i = 0; i < N_OBJ; i++) begin
            if (flash_trig && int'(flash_idx) == i) m_fl[i] = FLASH_FRAMES;
            else if (frame_start && m_fl[i] > 0)    m_fl[i] = m_fl[i] - 1;
        end
        if (wr_en && int'(wr_idx) < N_OBJ) begin
            m_sh[wr_idx].x   = int'(wr_x);
            m_sh[wr_idx].y   = int'(wr_y);
            m_sh[wr_idx].sx  = int'(wr_sx);
            m_sh[wr_idx].sy  = int'(wr_sy);
            m_sh[wr_idx].rgb = int'(wr_rgb);
            m_sh[wr_idx].vis = wr_vis;
        end
    endfunction

    // One clock: record what the driven pixel must become two edges later,
    // then compare the pixel that was driven two cycles ago.
    task automatic cycle();
        pix_t e;
        exp_q.push_back(model_pix(int'(DrawX), int'(DrawY), de));
        model_apply();
        @(posedge Clk); #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("rgb", {8'h00, Red, Green, Blue}, e.rgb);
            check("valid", {31'd0, pix_valid}, {31'd0, e.v});
        end
        de = 1'b0; frame_start = 1'b0; wr_en = 1'b0; flash_trig = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int idx, input int x, input int y, input int sx, input int sy,
                      input int rgb, input bit vis, input bit with_fs);
        wr_en = 1'b1; wr_idx = IW'(idx);
        wr_x = W'(x); wr_y = W'(y); wr_sx = W'(sx); wr_sy = W'(sy);
        wr_rgb = 24'(rgb); wr_vis = vis; frame_start = with_fs;
        cycle();
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cycle();
    endtask

    task automatic flash(input int idx, input bit with_fs);
        flash_trig = 1'b1; flash_idx = IW'(idx); frame_start = with_fs;
        cycle();
    endtask

    task automatic scan(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            de = 1'b1; DrawX = W'(x); DrawY = W'(y);
            cycle();
        end
        idle(2);
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; de = 1'b0; DrawX = '0; DrawY = '0;
        wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_sx = '0; wr_sy = '0;
        wr_rgb = '0; wr_vis = 1'b0; flash_trig = 1'b0; flash_idx = '0;
        model_reset();

        phase = "reset";
        @(posedge Clk); #1;
        check("red", {24'd0, Red}, 32'd0);
        check("green", {24'd0, Green}, 32'd0);
        check("blue", {24'd0, Blue}, 32'd0);
        check("valid", {31'd0, pix_valid}, 32'd0);
        Reset = 1'b0;
        idle(2);

        phase = "bg_only";
        scan(5, 0, 20);

        phase = "single_box";
        wr(0, 100, 100, 20, 10, 32'hFF5500, 1'b1, 1'b0);
        fs();
        scan(100, 89, 111);
        scan(95, 99, 101);
        scan(94, 99, 101);

        phase = "overlap";
        wr(0, 50, 50, 10, 10, 32'h00FF00, 1'b1, 1'b0);
        wr(1, 52, 50, 10, 10, 32'hFF0000, 1'b1, 1'b0);
        fs();
        scan(50, 42, 60);
        wr(0, 50, 50, 10, 10, 32'h00FF00, 1'b0, 1'b0);
        fs();
        scan(50, 42, 60);

        phase = "no_tear";
        wr(0, 100, 100, 20, 10, 32'hFF5500, 1'b1, 1'b0);
        fs();
        wr(0, 200, 100, 20, 10, 32'hFF5500, 1'b1, 1'b0);
        scan(100, 98, 102);
        scan(100, 198, 202);
        fs();
        scan(100, 98, 102);
        scan(100, 198, 202);
        wr(0, 300, 100, 20, 10, 32'hFF5500, 1'b1, 1'b1);
        scan(100, 298, 302);
        scan(100, 198, 202);
        fs();
        scan(100, 298, 302);

        phase = "zero_width";
        wr(1, 600, 600, 0, 4, 32'h123456, 1'b1, 1'b0);
        fs();
        scan(600, 598, 602);
        scan(602, 599, 601);
        scan(603, 599, 601);

        phase = "flash";
        wr(2, 400, 400, 8, 8, 32'h0000FF, 1'b1, 1'b0);
        fs();
        flash(2, 1'b0);
        scan(400, 395, 405);
        repeat (3) begin
            fs();
            scan(400, 398, 402);
        end
        flash(2, 1'b1);
        scan(400, 399, 401);
        repeat (3) begin
            fs();
            scan(400, 399, 401);
        end
        flash(3, 1'b0);
        scan(400, 399, 401);

        phase = "reset_mid";
        wr(0, 100, 100, 20, 10, 32'hFF5500, 1'b1, 1'b0);
        fs();
        for (int x = 95; x <= 99; x++) begin
            de = 1'b1; DrawX = W'(x); DrawY = W'(100);
            cycle();
        end
        de = 1'b1; DrawX = W'(100); DrawY = W'(100);
        #2 Reset = 1'b1;
        #1;
        check("red", {24'd0, Red}, 32'd0);
        check("green", {24'd0, Green}, 32'd0);
        check("blue", {24'd0, Blue}, 32'd0);
        check("valid", {31'd0, pix_valid}, 32'd0);
        exp_q.delete();
        model_reset();
        de = 1'b0;
        @(posedge Clk); #1;
        check("held_valid", {31'd0, pix_valid}, 32'd0);
        Reset = 1'b0;
        scan(100, 95, 105);
        wr(3, 100, 100, 20, 10, 32'hABCDEF, 1'b1, 1'b0);
        fs();
        scan(100, 95, 105);

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 12))
                0, 1: wr($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 63), $urandom_range(0, 63), $urandom & 32'hFFFFFF,
                         ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
                2:    fs();
                3:    flash($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                4: begin
                    DrawX = W'($urandom_range(0, 1023)); DrawY = W'($urandom_range(0, 1023));
                    cycle();
                end
                default: begin
                    de = 1'b1;
                    DrawX = W'($urandom_range(0, 300)); DrawY = W'($urandom_range(0, 300));
                    cycle();
                end
            endcase
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
